// File: rtl/traffic_light_pkg.sv
// Shared phase encodings and default timing for the traffic-light slice.
// Imported by the controller and by the phase timer.
package traffic_light_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RED    = 2'b01,
    GREEN  = 2'b10,
    YELLOW = 2'b11
  } phase_t;

  localparam int CNT_W_DEF = 8;
  localparam int RED_DEF_T = 10;
  localparam int YEL_DEF_T = 3;
  localparam int GRN_DEF_T = 8;
endpackage

// File: rtl/tick_prescaler.sv
// Cycle prescaler: divides the clock into time units.
// tick marks the last cycle of a unit while enabled.
module tick_prescaler
  import traffic_light_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;

  assign tick = en && (pre == LAST);

  // count cycles within a unit; clear wins, idle holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == LAST) ? '0 : pre + PW'(1);
    end
  end
endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timing datapath for the traffic-light controller.
// Durations are latched into the active set only at clear.
module traffic_phase_timer
  import traffic_light_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TICK_DIV = 1,
  parameter int RED_DEF  = RED_DEF_T,
  parameter int YEL_DEF  = YEL_DEF_T,
  parameter int GRN_DEF  = GRN_DEF_T
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             green,
  input  logic             yellow,
  input  logic             clear,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             err_clr,
  output logic             eq_red_time,
  output logic             eq_yellow_time,
  output logic             eq_green_time,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_err
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_red, pend_grn, pend_yel;
  logic [CNT_W-1:0] act_red, act_grn, act_yel;
  logic [CNT_W-1:0] dsel, dur;
  logic multi_lit, one_lit, tick, last;
  logic wr_red, wr_grn, wr_yel;

  assign multi_lit = (red && green) || (red && yellow)
                   || (green && yellow);
  assign one_lit   = (red || green || yellow) && !multi_lit;

  assign wr_red = cfg_we && (cfg_sel == RED);
  assign wr_grn = cfg_we && (cfg_sel == GREEN);
  assign wr_yel = cfg_we && (cfg_sel == YELLOW);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_pre (
    .clk  (clk),
    .reset(reset),
    .clr  (clear),
    .en   (one_lit),
    .tick (tick)
  );

  // pick the active duration of the single lit phase
  always_comb begin
    dsel = '0;
    unique case (1'b1)
      one_lit && red:    dsel = act_red;
      one_lit && green:  dsel = act_grn;
      one_lit && yellow: dsel = act_yel;
      default:           dsel = '0;
    endcase
  end

  assign dur  = (dsel == '0) ? CNT_W'(1) : dsel;
  assign last = tick && (cnt >= dur - CNT_W'(1));

  assign eq_red_time    = red && last;
  assign eq_yellow_time = yellow && last;
  assign eq_green_time  = green && last;

  assign remaining = (one_lit && (dur > cnt)) ? dur - cnt : '0;

  // phase unit counter, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // pending durations take writes at any time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_red <= CNT_W'(RED_DEF);
      pend_grn <= CNT_W'(GRN_DEF);
      pend_yel <= CNT_W'(YEL_DEF);
    end else begin
      if (wr_red) pend_red <= cfg_data;
      if (wr_grn) pend_grn <= cfg_data;
      if (wr_yel) pend_yel <= cfg_data;
    end
  end

  // active durations update at phase boundaries, with write bypass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_red <= CNT_W'(RED_DEF);
      act_grn <= CNT_W'(GRN_DEF);
      act_yel <= CNT_W'(YEL_DEF);
    end else if (clear) begin
      act_red <= wr_red ? cfg_data : pend_red;
      act_grn <= wr_grn ? cfg_data : pend_grn;
      act_yel <= wr_yel ? cfg_data : pend_yel;
    end
  end

  // sticky multi-light error, set beats clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_err <= 1'b0;
    end else if (multi_lit) begin
      phase_err <= 1'b1;
    end else if (err_clr) begin
      phase_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer.
// Two instances: TICK_DIV=1 and TICK_DIV=4.
module tb_traffic_phase_timer;
  logic       clk = 1'b0;
  logic       reset;
  logic       red, green, yellow, clear;
  logic       cfg_we, err_clr;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_data;

  logic       a_er, a_ey, a_eg, a_err;
  logic [7:0] a_rem;
  logic       b_er, b_ey, b_eg, b_err;
  logic [7:0] b_rem;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_phase_timer #(.TICK_DIV(1)) u_dut (
    .clk(clk), .reset(reset),
    .red(red), .green(green), .yellow(yellow),
    .clear(clear), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .err_clr(err_clr),
    .eq_red_time(a_er), .eq_yellow_time(a_ey),
    .eq_green_time(a_eg), .remaining(a_rem),
    .phase_err(a_err)
  );

  traffic_phase_timer #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .red(red), .green(green), .yellow(yellow),
    .clear(clear), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .err_clr(err_clr),
    .eq_red_time(b_er), .eq_yellow_time(b_ey),
    .eq_green_time(b_eg), .remaining(b_rem),
    .phase_err(b_err)
  );

  task automatic check(input string tag,
                       input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lights(input logic r, input logic g,
                        input logic y);
    red = r;
    green = g;
    yellow = y;
  endtask

  task automatic do_clear();
    lights(0, 0, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    lights(0, 0, 0);
    clear = 0; cfg_we = 0; err_clr = 0;
    cfg_sel = 2'b00; cfg_data = 8'd0;
    step();
    step();
    check("rst_eq", {a_er, a_ey, a_eg, b_er, b_ey, b_eg}, 0);
    check("rst_rem", a_rem, 0);
    check("rst_err", a_err, 0);
    reset = 1'b0;
    do_clear();

    lights(1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      #1;
      check("red_rem", a_rem, 11 - i);
      check("red_eq", a_er, (i == 10) ? 1 : 0);
      step();
    end
    do_clear();

    lights(0, 0, 1);
    for (int i = 1; i <= 12; i++) begin
      #1;
      check("y4_eq", b_ey, (i == 12) ? 1 : 0);
      check("y4_rem", b_rem, 3 - (i - 1) / 4);
      if (i == 12) check("y1_clamp", a_rem, 0);
      step();
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    check("y4_rst_rem", b_rem, 3);
    check("y4_rst_eq", b_ey, 0);
    do_clear();

    lights(0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        cfg_we = 1; cfg_sel = 2'b10; cfg_data = 8'd5;
      end else begin
        cfg_we = 0;
      end
      #1;
      check("g8_eq", a_eg, (i == 8) ? 1 : 0);
      step();
    end
    cfg_we = 0;
    do_clear();
    lights(0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      #1;
      if (i == 1) check("g5_rem", a_rem, 5);
      check("g5_eq", a_eg, (i == 5) ? 1 : 0);
      step();
    end

    lights(0, 0, 0);
    clear = 1; cfg_we = 1; cfg_sel = 2'b01; cfg_data = 8'd2;
    step();
    clear = 0; cfg_we = 0;
    lights(1, 0, 0);
    for (int i = 1; i <= 2; i++) begin
      #1;
      check("r2_rem", a_rem, 3 - i);
      check("r2_eq", a_er, (i == 2) ? 1 : 0);
      step();
    end
    do_clear();

    cfg_we = 1; cfg_sel = 2'b11; cfg_data = 8'd0;
    step();
    cfg_we = 0;
    do_clear();
    lights(0, 0, 1);
    #1;
    check("y0_rem", a_rem, 1);
    check("y0_eq", a_ey, 1);
    step();
    do_clear();

    lights(1, 1, 0);
    #1;
    check("multi_eq", {a_er, a_ey, a_eg}, 0);
    check("multi_rem", a_rem, 0);
    check("err_pre", a_err, 0);
    step();
    check("err_set", a_err, 1);
    lights(0, 0, 0);
    step();
    check("err_sticky", a_err, 1);
    err_clr = 1;
    step();
    check("err_clr", a_err, 0);
    lights(0, 1, 1);
    step();
    check("err_prio", a_err, 1);
    err_clr = 0;
    do_clear();

    lights(1, 0, 0);
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_err", a_err, 0);
    check("mid_rst_red", a_rem, 10);
    lights(0, 0, 1);
    #1;
    check("mid_rst_yel", a_rem, 3);
    lights(0, 1, 0);
    #1;
    check("mid_rst_grn", a_rem, 8);
    lights(0, 0, 0);
    step();
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
